ecall_io_responder: RTL and testbench

ECALL_IO_RESPONDER -- requirements
Module: ecall_io_responder

---
 rtl/ecall_pkg.sv | 27 ++
 rtl/ecall_io_responder_if.sv | 24 ++
 rtl/button_debounce.sv | 44 ++++
 rtl/ecall_io_responder.sv | 106 ++++++++++
 tb/tb_ecall_io_responder.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ecall_pkg.sv
// Shared definitions for the ecall I/O responder: bus widths, service
// codes, FSM state encoding and the switch sign-extension helper.
package ecall_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SW_W  = 16;
  localparam int unsigned LED_W = 8;

  // Service numbers carried in a7
  localparam logic [XLEN-1:0] CODE_PRINT_INT = 32'd1;
  localparam logic [XLEN-1:0] CODE_READ_INT  = 32'd5;
  localparam logic [XLEN-1:0] CODE_EXIT      = 32'd10;
  localparam logic [XLEN-1:0] CODE_PC_CHANGE = 32'd11;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRINT_WAIT = 2'd1,
    READ_WAIT  = 2'd2,
    READ_RSP   = 2'd3
  } state_e;

  // Switch bank is a signed 16-bit integer
  function automatic logic [XLEN-1:0] sext_sw(input logic [SW_W-1:0] v);
    return {{(XLEN-SW_W){v[SW_W-1]}}, v};
  endfunction

endpackage

// File: rtl/ecall_io_responder_if.sv
// CPU <-> responder ecall bus.
//   req_valid/req_code/req_data : one-cycle request from the CPU
//   cpu_stall                   : hold PC / suppress writeback
//   rsp_valid/rsp_data          : one-cycle read-integer result for a0
interface ecall_io_responder_if;
  import ecall_pkg::*;

  logic            req_valid;
  logic [XLEN-1:0] req_code;
  logic [XLEN-1:0] req_data;
  logic            cpu_stall;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;

  modport master (
    output req_valid, req_code, req_data,
    input  cpu_stall, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_code, req_data,
    output cpu_stall, rsp_valid, rsp_data
  );
endinterface

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted 0->1 level change.
//   clk, reset (async active-low), btn (raw), press (registered pulse)
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // A new level is accepted after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= 2'b00;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CNT_MAX) begin
          level <= sync[1];
          cnt   <= '0;
          press <= sync[1];
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ecall_io_responder.sv
// Services CPU ecalls against board I/O: print-int to the 7-segment
// display, read-int from switches, exit LED and test-case select pulse.
//   clk, reset (async active-low), cpu (ecall bus, slave side)
//   sw_in, confirm_btn : board inputs
//   disp_data/disp_valid, led_out, pc_change : board outputs
module ecall_io_responder
  import ecall_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  ecall_io_responder_if.slave  cpu,
  input  logic [SW_W-1:0]      sw_in,
  input  logic                 confirm_btn,
  output logic [XLEN-1:0]      disp_data,
  output logic                 disp_valid,
  output logic [LED_W-1:0]     led_out,
  output logic                 pc_change
);

  state_e          state_q, state_d;
  logic            press;
  logic [XLEN-1:0] disp_data_d, rsp_data_q, rsp_data_d;
  logic            disp_valid_d, rsp_valid_q, rsp_valid_d, pc_change_d;
  logic            exit_d;
  logic [LED_W-1:0] led_d;
  logic            svc_req;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk   (clk),
    .reset (reset),
    .btn   (confirm_btn),
    .press (press)
  );

  // Stall must rise in the request cycle itself so the ecall does not retire
  assign svc_req = (state_q == IDLE) && cpu.req_valid &&
                   ((cpu.req_code == CODE_PRINT_INT) || (cpu.req_code == CODE_READ_INT));
  assign cpu.cpu_stall = reset && (svc_req || (state_q == PRINT_WAIT) || (state_q == READ_WAIT));
  assign cpu.rsp_valid = rsp_valid_q;
  assign cpu.rsp_data  = rsp_data_q;

  // Next-state and next-output decode
  always_comb begin
    state_d      = state_q;
    disp_data_d  = disp_data;
    disp_valid_d = disp_valid;
    rsp_data_d   = rsp_data_q;
    rsp_valid_d  = 1'b0;
    pc_change_d  = 1'b0;
    exit_d       = led_out[0];
    case (state_q)
      IDLE: begin
        if (cpu.req_valid) begin
          case (cpu.req_code)
            CODE_PRINT_INT: begin
              state_d      = PRINT_WAIT;
              disp_data_d  = cpu.req_data;
              disp_valid_d = 1'b1;
            end
            CODE_READ_INT:  state_d     = READ_WAIT;
            CODE_EXIT:      exit_d      = 1'b1;
            CODE_PC_CHANGE: pc_change_d = 1'b1;
            default: ;
          endcase
        end
      end
      PRINT_WAIT: begin
        if (press) state_d = IDLE;
      end
      READ_WAIT: begin
        if (press) begin
          state_d     = READ_RSP;
          rsp_data_d  = sext_sw(sw_in);
          rsp_valid_d = 1'b1;
        end
      end
      READ_RSP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    led_d = {(state_d == READ_WAIT), (state_d == PRINT_WAIT), 5'b00000, exit_d};
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      disp_data   <= '0;
      disp_valid  <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      pc_change   <= 1'b0;
      led_out     <= '0;
    end else begin
      state_q     <= state_d;
      disp_data   <= disp_data_d;
      disp_valid  <= disp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      pc_change   <= pc_change_d;
      led_out     <= led_d;
    end
  end

endmodule

// File: tb/tb_ecall_io_responder.sv
// Scoreboard bench for ecall_io_responder with DEBOUNCE_CYCLES=4.
module tb_ecall_io_responder;
  import ecall_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [SW_W-1:0]   sw_in;
  logic              confirm_btn;
  logic [XLEN-1:0]   disp_data;
  logic              disp_valid;
  logic [LED_W-1:0]  led_out;
  logic              pc_change;

  int n_chk  = 0;
  int n_fail = 0;
  int rsp_cnt = 0;
  int pc_cnt  = 0;
  logic [31:0] exp_q[$];

  ecall_io_responder_if cpu_if ();

  ecall_io_responder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .cpu         (cpu_if),
    .sw_in       (sw_in),
    .confirm_btn (confirm_btn),
    .disp_data   (disp_data),
    .disp_valid  (disp_valid),
    .led_out     (led_out),
    .pc_change   (pc_change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Response monitor pops the scoreboard on every rsp_valid pulse
  always @(negedge clk) begin
    if (cpu_if.rsp_valid === 1'b1) begin
      rsp_cnt++;
      chk("rsp_stall_low", 32'(cpu_if.cpu_stall), 32'd0);
      chk("rsp_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("rsp_data", cpu_if.rsp_data, exp_q.pop_front());
    end
    if (pc_change === 1'b1) pc_cnt++;
  end

  task automatic issue(input logic [31:0] code, input logic [31:0] data, input logic exp_stall);
    @(negedge clk);
    cpu_if.req_valid = 1'b1;
    cpu_if.req_code  = code;
    cpu_if.req_data  = data;
    #1 chk("stall_on_req", 32'(cpu_if.cpu_stall), 32'(exp_stall));
    @(negedge clk);
    cpu_if.req_valid = 1'b0;
    cpu_if.req_code  = '0;
    cpu_if.req_data  = '0;
  endtask

  task automatic set_btn(input logic v, input int cycles);
    confirm_btn = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic wait_stall_low(input string tag, input int budget);
    int  n = 0;
    bit  done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      if (cpu_if.cpu_stall === 1'b0) done = 1'b1;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int start = rsp_cnt;
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      #2;
      n++;
      if (rsp_cnt != start) done = 1'b1;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_stall"},      32'(cpu_if.cpu_stall), 32'd0);
    chk({pfx, "_rsp_valid"},  32'(cpu_if.rsp_valid), 32'd0);
    chk({pfx, "_rsp_data"},   cpu_if.rsp_data,       32'd0);
    chk({pfx, "_disp_valid"}, 32'(disp_valid),       32'd0);
    chk({pfx, "_disp_data"},  disp_data,             32'd0);
    chk({pfx, "_led"},        32'(led_out),          32'd0);
    chk({pfx, "_pc_change"},  32'(pc_change),        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int start;
    rst_n            = 1'b0;
    sw_in            = '0;
    confirm_btn      = 1'b0;
    cpu_if.req_valid = 1'b0;
    cpu_if.req_code  = '0;
    cpu_if.req_data  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Print: stall in the request cycle, display loaded, clean press releases
    issue(CODE_PRINT_INT, 32'h0000_002A, 1'b1);
    chk("print_disp_data",  disp_data, 32'h0000_002A);
    chk("print_disp_valid", 32'(disp_valid), 32'd1);
    chk("print_led",        32'(led_out), 32'h40);
    chk("print_stalled",    32'(cpu_if.cpu_stall), 32'd1);
    set_btn(1'b1, 0);
    wait_stall_low("print_release_7cyc", 7);
    chk("print_led_after", 32'(led_out), 32'h00);
    chk("print_disp_kept", disp_data, 32'h0000_002A);
    set_btn(1'b0, 10);

    // Read: negative and positive switch values
    sw_in = 16'hFFFE;
    exp_q.push_back(32'hFFFF_FFFE);
    issue(CODE_READ_INT, 32'h0, 1'b1);
    chk("read_led", 32'(led_out), 32'h80);
    set_btn(1'b1, 0);
    wait_rsp("read_neg_rsp", 10);
    set_btn(1'b0, 10);
    chk("read_disp_kept", disp_data, 32'h0000_002A);

    sw_in = 16'h7FFF;
    exp_q.push_back(32'h0000_7FFF);
    issue(CODE_READ_INT, 32'h0, 1'b1);
    set_btn(1'b1, 0);
    wait_rsp("read_pos_rsp", 10);
    // Request in the first cycle back in IDLE is accepted
    issue(CODE_PRINT_INT, 32'h0000_0077, 1'b1);
    chk("back2back_disp", disp_data, 32'h0000_0077);
    chk("rsp_data_held", cpu_if.rsp_data, 32'h0000_7FFF);
    set_btn(1'b0, 10);
    set_btn(1'b1, 0);
    wait_stall_low("back2back_release", 8);
    set_btn(1'b0, 10);

    // Bounce: short glitches never reach the debounce threshold
    sw_in = 16'h1234;
    exp_q.push_back(32'h0000_1234);
    start = rsp_cnt;
    issue(CODE_READ_INT, 32'h0, 1'b1);
    repeat (3) begin
      set_btn(1'b1, 3);
      set_btn(1'b0, 3);
    end
    chk("bounce_no_rsp", 32'(rsp_cnt - start), 32'd0);
    chk("bounce_stalled", 32'(cpu_if.cpu_stall), 32'd1);
    set_btn(1'b1, 0);
    wait_rsp("bounce_rsp", 10);
    repeat (10) @(negedge clk);
    chk("bounce_one_rsp", 32'(rsp_cnt - start), 32'd1);
    set_btn(1'b0, 10);

    // Held button: read needs release and re-press
    issue(CODE_PRINT_INT, 32'h0000_0055, 1'b1);
    set_btn(1'b1, 0);
    wait_stall_low("held_print_release", 8);
    sw_in = 16'h0001;
    exp_q.push_back(32'h0000_0001);
    start = rsp_cnt;
    issue(CODE_READ_INT, 32'h0, 1'b1);
    repeat (20) @(negedge clk);
    chk("held_no_rsp", 32'(rsp_cnt - start), 32'd0);
    chk("held_stalled", 32'(cpu_if.cpu_stall), 32'd1);
    set_btn(1'b0, 10);
    chk("held_release_stalled", 32'(cpu_if.cpu_stall), 32'd1);
    set_btn(1'b1, 0);
    wait_rsp("held_repress_rsp", 10);
    set_btn(1'b0, 10);

    // Misc codes
    start = rsp_cnt;
    chk("misc_led_before", 32'(led_out), 32'h00);
    issue(CODE_EXIT, 32'h0, 1'b0);
    chk("exit_led", 32'(led_out), 32'h01);
    begin
      int pc0 = pc_cnt;
      issue(CODE_PC_CHANGE, 32'h0, 1'b0);
      repeat (5) @(negedge clk);
      chk("pc_change_one_pulse", 32'(pc_cnt - pc0), 32'd1);
    end
    issue(32'd7, 32'hFFFF_FFFF, 1'b0);
    repeat (3) @(negedge clk);
    chk("code7_stall", 32'(cpu_if.cpu_stall), 32'd0);
    chk("code7_led_sticky", 32'(led_out), 32'h01);
    chk("code7_disp", disp_data, 32'h0000_0055);
    chk("misc_no_rsp", 32'(rsp_cnt - start), 32'd0);

    // Reset in READ_WAIT aborts with no response
    sw_in = 16'h4321;
    start = rsp_cnt;
    issue(CODE_READ_INT, 32'h0, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 check_all_zero("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_cnt - start), 32'd0);
    issue(CODE_PRINT_INT, 32'hDEAD_BEEF, 1'b1);
    chk("post_reset_disp", disp_data, 32'hDEAD_BEEF);
    chk("post_reset_led", 32'(led_out), 32'h40);
    set_btn(1'b1, 0);
    wait_stall_low("post_reset_release", 8);
    set_btn(1'b0, 5);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
